// File: rtl/tlb_plru_assoc.sv
// Set-associative, PCID-tagged TLB with per-set tree-PLRU replacement and a set-by-set flush.
// Define TLB_PERF_CNT_EN to build the saturating hit/miss counters; otherwise they read as 0.
module tlb_plru_assoc #(
    parameter int unsigned ADDR   = 64,
    parameter int unsigned PAGE   = 12,
    parameter int unsigned PCID_W = 12,
    parameter int unsigned WAYS   = 8,
    parameter int unsigned SETS   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR-1:0]      req_vaddr,
    input  logic [PCID_W-1:0]    req_pcid,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic [ADDR-1:0]      resp_paddr,
    input  logic                 fill_valid,
    output logic                 fill_ready,
    input  logic [ADDR-1:0]      fill_vaddr,
    input  logic [PCID_W-1:0]    fill_pcid,
    input  logic [ADDR-PAGE-1:0] fill_ppn,
    input  logic                 flush_valid,
    input  logic                 flush_all,
    input  logic [PCID_W-1:0]    flush_pcid,
    output logic                 flush_done,
    output logic [31:0]          perf_hits,
    output logic [31:0]          perf_misses
);
    localparam int unsigned SIDX  = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR - PAGE - SIDX;
    localparam int unsigned PPN_W = ADDR - PAGE;
    localparam int unsigned WIDX  = $clog2(WAYS);
    localparam int unsigned NODES = WAYS - 1;

    typedef enum logic {IDLE, FLUSH} state_e;

    state_e                            state_q, state_d;
    logic [SIDX-1:0]                   flush_idx_q;
    logic                              flush_all_q;
    logic [PCID_W-1:0]                 flush_pcid_q;
    logic [SETS-1:0][WAYS-1:0]         valid_q;
    logic [SETS-1:0][NODES-1:0]        plru_q;
    logic [TAG_W-1:0]                  tag_q  [SETS][WAYS];
    logic [PCID_W-1:0]                 pcid_q [SETS][WAYS];
    logic [PPN_W-1:0]                  ppn_q  [SETS][WAYS];

    logic            req_fire, fill_fire, flush_start;
    logic [SIDX-1:0] req_set, fill_set, acc_set;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic            lk_hit, dup_hit, has_inv, acc_valid;
    logic [WIDX-1:0] lk_way, dup_way, inv_way, fill_way, acc_way;
    logic            fill_unused_c;

    // Victim walk: each node bit names the subtree holding the next victim (0 = left).
    function automatic logic [WIDX-1:0] plru_victim(input logic [NODES-1:0] bits);
        logic [WIDX-1:0] node;
        plru_victim = '0;
        node        = '0;
        for (int l = int'(WIDX) - 1; l >= 0; l--) begin
            plru_victim[l] = bits[node];
            node = WIDX'(2 * 32'(node) + 1 + 32'(bits[node]));
        end
    endfunction

    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                    input logic [WIDX-1:0]  way);
        logic [WIDX-1:0] node;
        plru_touch = bits;
        node       = '0;
        for (int l = int'(WIDX) - 1; l >= 0; l--) begin
            plru_touch[node] = ~way[l];
            node = WIDX'(2 * 32'(node) + 1 + 32'(way[l]));
        end
    endfunction

    assign req_set       = req_vaddr[PAGE+SIDX-1:PAGE];
    assign req_tag       = req_vaddr[ADDR-1:PAGE+SIDX];
    assign fill_set      = fill_vaddr[PAGE+SIDX-1:PAGE];
    assign fill_tag      = fill_vaddr[ADDR-1:PAGE+SIDX];
    assign fill_unused_c = ^fill_vaddr[PAGE-1:0];
    assign req_fire      = req_valid && req_ready;
    assign fill_fire     = fill_valid && fill_ready;
    assign flush_start   = flush_valid && (state_q == IDLE);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (flush_valid) state_d = FLUSH;
            FLUSH:   if (flush_idx_q == SIDX'(SETS - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: flush outranks fill, fill outranks lookup
    always_comb begin
        req_ready  = 1'b0;
        fill_ready = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready  = !fill_valid && !flush_valid;
                fill_ready = !flush_valid;
            end
            FLUSH:   flush_done = (flush_idx_q == SIDX'(SETS - 1));
            default: ;
        endcase
    end

    // Lookup compare and fill way selection
    always_comb begin
        lk_hit  = 1'b0;
        lk_way  = '0;
        dup_hit = 1'b0;
        dup_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag &&
                pcid_q[req_set][w] == req_pcid) begin
                lk_hit = 1'b1;
                lk_way = WIDX'(w);
            end
            if (valid_q[fill_set][w] && tag_q[fill_set][w] == fill_tag &&
                pcid_q[fill_set][w] == fill_pcid) begin
                dup_hit = 1'b1;
                dup_way = WIDX'(w);
            end
        end
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[fill_set][w]) begin
                has_inv = 1'b1;
                inv_way = WIDX'(w);
            end
        end
        fill_way = dup_hit ? dup_way : (has_inv ? inv_way : plru_victim(plru_q[fill_set]));
        acc_valid = fill_fire || (req_fire && lk_hit);
        acc_set   = fill_fire ? fill_set : req_set;
        acc_way   = fill_fire ? fill_way : lk_way;
    end

    // Valid bits and PLRU state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            plru_q  <= '0;
        end else begin
            if (fill_fire) valid_q[fill_set][fill_way] <= 1'b1;
            if (acc_valid) plru_q[acc_set] <= plru_touch(plru_q[acc_set], acc_way);
            if (state_q == FLUSH) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    if (flush_all_q || pcid_q[flush_idx_q][w] == flush_pcid_q)
                        valid_q[flush_idx_q][w] <= 1'b0;
                end
            end
        end
    end

    // Entry payload needs no reset: it is only observed through valid
    always_ff @(posedge clk) begin
        if (fill_fire) begin
            tag_q[fill_set][fill_way]  <= fill_tag;
            pcid_q[fill_set][fill_way] <= fill_pcid;
            ppn_q[fill_set][fill_way]  <= fill_ppn;
        end
    end

    // Flush scan pointer and latched flush request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_idx_q  <= '0;
            flush_all_q  <= 1'b0;
            flush_pcid_q <= '0;
        end else if (flush_start) begin
            flush_idx_q  <= '0;
            flush_all_q  <= flush_all;
            flush_pcid_q <= flush_pcid;
        end else if (state_q == FLUSH) begin
            flush_idx_q  <= flush_idx_q + SIDX'(1);
        end
    end

    // Registered lookup response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_paddr <= '0;
        end else begin
            resp_valid <= req_fire;
            resp_hit   <= req_fire && lk_hit;
            resp_paddr <= (req_fire && lk_hit) ? {ppn_q[req_set][lk_way], req_vaddr[PAGE-1:0]}
                                               : '0;
        end
    end

`ifdef TLB_PERF_CNT_EN
    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (resp_valid) begin
            if (resp_hit && perf_hits != 32'hFFFF_FFFF)     perf_hits   <= perf_hits + 32'd1;
            if (!resp_hit && perf_misses != 32'hFFFF_FFFF)  perf_misses <= perf_misses + 32'd1;
        end
    end
`else
    assign perf_hits   = '0;
    assign perf_misses = '0;
`endif

endmodule

// File: tb/tb_tlb_plru_assoc.sv
// Scoreboard bench for tlb_plru_assoc: lookups push expected responses, a negedge monitor pops them.
module tb_tlb_plru_assoc;
    localparam int unsigned ADDR = 64, PAGE = 12, PCID_W = 12, WAYS = 8, SETS = 8;
`ifdef TLB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                 clk = 1'b0, rst_n = 1'b0;
    logic                 req_valid = 1'b0, req_ready;
    logic [ADDR-1:0]      req_vaddr = '0;
    logic [PCID_W-1:0]    req_pcid = '0;
    logic                 resp_valid, resp_hit;
    logic [ADDR-1:0]      resp_paddr;
    logic                 fill_valid = 1'b0, fill_ready;
    logic [ADDR-1:0]      fill_vaddr = '0;
    logic [PCID_W-1:0]    fill_pcid = '0;
    logic [ADDR-PAGE-1:0] fill_ppn = '0;
    logic                 flush_valid = 1'b0, flush_all = 1'b0;
    logic [PCID_W-1:0]    flush_pcid = '0;
    logic                 flush_done;
    logic [31:0]          perf_hits, perf_misses;

    tlb_plru_assoc #(.ADDR(ADDR), .PAGE(PAGE), .PCID_W(PCID_W), .WAYS(WAYS), .SETS(SETS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr), .req_pcid(req_pcid),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_paddr(resp_paddr),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_vaddr(fill_vaddr),
        .fill_pcid(fill_pcid), .fill_ppn(fill_ppn),
        .flush_valid(flush_valid), .flush_all(flush_all), .flush_pcid(flush_pcid),
        .flush_done(flush_done), .perf_hits(perf_hits), .perf_misses(perf_misses)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic [63:0] paddr;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("resp_cycle", 64'(cyc), 64'(e.cyc));
                check("resp_hit", 64'(resp_hit), 64'(e.hit));
                check("resp_paddr", resp_paddr, e.paddr);
            end
        end
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic lookup(input logic [63:0] va, input logic [11:0] pc,
                          input logic hit, input logic [51:0] ppn);
        exp_t e;
        req_valid = 1'b1;
        req_vaddr = va;
        req_pcid  = pc;
        #1;
        check("req_ready", 64'(req_ready), 64'd1);
        e.hit   = hit;
        e.paddr = hit ? {ppn, va[11:0]} : 64'd0;
        e.cyc   = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic fill(input logic [63:0] va, input logic [11:0] pc, input logic [51:0] ppn);
        fill_valid = 1'b1;
        fill_vaddr = va;
        fill_pcid  = pc;
        fill_ppn   = ppn;
        #1;
        check("fill_ready", 64'(fill_ready), 64'd1);
        check("req_ready_during_fill", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        fill_valid = 1'b0;
    endtask

    task automatic flush(input logic all, input logic [11:0] pc);
        flush_valid = 1'b1;
        flush_all   = all;
        flush_pcid  = pc;
        #1;
        check("flush_req_ready", 64'(req_ready), 64'd0);
        check("flush_fill_ready", 64'(fill_ready), 64'd0);
        @(posedge clk); #1;
        flush_valid = 1'b0;
        for (int k = 1; k <= int'(SETS); k++) begin
            #1;
            check("flush_busy_req_ready", 64'(req_ready), 64'd0);
            check("flush_busy_fill_ready", 64'(fill_ready), 64'd0);
            check("flush_done_timing", 64'(flush_done), 64'(k == int'(SETS)));
            @(posedge clk); #1;
        end
        check("flush_end_req_ready", 64'(req_ready), 64'd1);
        check("flush_end_done", 64'(flush_done), 64'd0);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        fill_valid  = 1'b0;
        flush_valid = 1'b0;
        sb.delete();
        #1;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_hit", 64'(resp_hit), 64'd0);
        check("rst_resp_paddr", resp_paddr, 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_fill_ready", 64'(fill_ready), 64'd1);
        check("rst_perf_hits", 64'(perf_hits), 64'd0);
        check("rst_perf_misses", 64'(perf_misses), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        do_reset();

        // Empty TLB misses with zero paddr
        lookup(64'h5123, 12'd3, 1'b0, '0);
        drain();

        // Basic fill/hit, PCID mismatch, in-place refill
        fill(64'h5000, 12'd3, 52'hABCDE);
        lookup(64'h5123, 12'd3, 1'b1, 52'hABCDE);
        lookup(64'h5123, 12'd4, 1'b0, '0);
        fill(64'h5000, 12'd3, 52'h12345);
        lookup(64'h5FFF, 12'd3, 1'b1, 52'h12345);
        drain();

        // Nine tags into set 5: first one is the victim
        do_reset();
        for (int t = 1; t <= 9; t++) fill((64'(t) << 15) | 64'h5000, 12'd3, 52'(32'h100 + t));
        lookup((64'd1 << 15) | 64'h5abc, 12'd3, 1'b0, '0);
        for (int t = 2; t <= 9; t++)
            lookup((64'(t) << 15) | 64'h5abc, 12'd3, 1'b1, 52'(32'h100 + t));
        drain();

        // Recently used tag survives; PLRU picks tag 5
        for (int t = 1; t <= 8; t++) fill((64'(t) << 15) | 64'h2000, 12'd3, 52'(32'h200 + t));
        lookup((64'd1 << 15) | 64'h2010, 12'd3, 1'b1, 52'h201);
        fill((64'd9 << 15) | 64'h2000, 12'd3, 52'h209);
        lookup((64'd1 << 15) | 64'h2020, 12'd3, 1'b1, 52'h201);
        lookup((64'd5 << 15) | 64'h2030, 12'd3, 1'b0, '0);
        lookup((64'd9 << 15) | 64'h2040, 12'd3, 1'b1, 52'h209);
        drain();

        // PCID-selective flush, then flush-all
        do_reset();
        fill(64'h1000, 12'd1, 52'h11);
        fill(64'h1000, 12'd2, 52'h22);
        fill(64'h7000, 12'd1, 52'h77);
        flush(1'b0, 12'd1);
        lookup(64'h1abc, 12'd1, 1'b0, '0);
        lookup(64'h7abc, 12'd1, 1'b0, '0);
        lookup(64'h1abc, 12'd2, 1'b1, 52'h22);
        drain();
        flush(1'b1, 12'd0);
        lookup(64'h1abc, 12'd2, 1'b0, '0);
        drain();

        // Reset in the middle of a flush
        fill(64'h3000, 12'd5, 52'h33);
        flush_valid = 1'b1;
        flush_all   = 1'b0;
        flush_pcid  = 12'd9;
        @(posedge clk); #1;
        flush_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        for (int k = 0; k < int'(SETS) + 2; k++) begin
            #1;
            check("no_flush_done_after_rst", 64'(flush_done), 64'd0);
            @(posedge clk); #1;
        end
        lookup(64'h3000, 12'd5, 1'b0, '0);
        drain();

        // Reset while back-to-back hits are in flight
        fill(64'h4000, 12'd6, 52'h44);
        lookup(64'h4001, 12'd6, 1'b1, 52'h44);
        lookup(64'h4002, 12'd6, 1'b1, 52'h44);
        do_reset();
        lookup(64'h4003, 12'd6, 1'b0, '0);
        drain();

        // Performance counters
        do_reset();
        fill(64'h6000, 12'd7, 52'h66);
        for (int i = 0; i < 3; i++) lookup(64'h6000 + 64'(i), 12'd7, 1'b1, 52'h66);
        for (int i = 0; i < 2; i++) lookup(64'h6000 + 64'(i), 12'd8, 1'b0, '0);
        drain();
        check("perf_hits", 64'(perf_hits), PERF ? 64'd3 : 64'd0);
        check("perf_misses", 64'(perf_misses), PERF ? 64'd2 : 64'd0);

        check("sb_final_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tlb_plru_assoc.md
# tlb_plru_assoc

Parametrised set-associative TLB with PCID tagging, per-set tree-PLRU replacement, separate lookup/fill/flush channels and a one-cycle lookup latency. It is the next generation of the TLB set array: it generalises way and set count, returns a translated physical address, supports explicit fills and PCID-selective flush, and replaces per-set enable strobes with a valid/ready handshake. It sits between the address-generation stage and the page-table walker.

## Interface
- ADDR, 64, virtual/physical address width
- PAGE, 12, page-offset bits
- PCID_W, 12, process-context-ID width
- WAYS, 8, ways per set, power of two, ≥2
- SETS, 8, number of sets, power of two, ≥2
- Derived: SIDX=$clog2(SETS); TAG_W=ADDR-PAGE-SIDX; PPN_W=ADDR-PAGE

- clk  in  1  clock, all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid / req_ready  in / out  1 / 1  lookup handshake
- req_vaddr  in  ADDR  virtual address
- req_pcid  in  PCID_W  context of lookup
- resp_valid  out  1  one-cycle response pulse
- resp_hit  out  1  1 = translation found
- resp_paddr  out  ADDR  {PPN, req_vaddr[PAGE-1:0]} on hit, 0 on miss
- fill_valid / fill_ready  in / out  1 / 1  fill handshake
- fill_vaddr  in  ADDR  virtual page to install
- fill_pcid  in  PCID_W  context of fill
- fill_ppn  in  PPN_W  physical page number
- flush_valid  in  1  start flush (single-cycle request)
- flush_all  in  1  1 = invalidate all; 0 = only entries with flush_pcid
- flush_pcid  in  PCID_W  context to flush
- flush_done  out  1  one-cycle pulse at flush end
- perf_hits, perf_misses  out  32  counters (see Configuration)

## Operation
- Entry: valid, tag (TAG_W), pcid, ppn. Set index = vaddr[PAGE+SIDX-1:PAGE]; tag = vaddr[ADDR-1:PAGE+SIDX].
- PLRU: WAYS-1 bits per set, node 0 root, children 2i+1/2i+2; bit 0 → victim in left subtree. Access of way w sets every node on its path to point away from w.
- FSM states IDLE, FLUSH.
- IDLE: req_ready=1 iff !fill_valid && !flush_valid. Priority flush > fill > lookup.
- Lookup (accepted): compare all ways of the set on valid && tag && pcid; register result. Hit → PLRU update for hit way. Miss → no allocation, PLRU unchanged.
- Fill (fill_ready=1 in IDLE): if a valid entry with same tag+pcid exists, overwrite its ppn in place; else write the lowest-index invalid way; else write the PLRU victim. Written way is marked accessed in PLRU.
- flush_valid in IDLE → FLUSH; scan one set per cycle, index 0..SETS-1; clear valid of matching entries; PLRU bits untouched. After last set: flush_done pulse, return to IDLE. flush_valid while in FLUSH ignored.
- Multiple hits are impossible by construction (fill dedups).

## Timing
- Reset: all valid bits 0, PLRU 0, FSM IDLE, resp_valid=0, resp_hit=0, resp_paddr=0, flush_done=0, counters 0. req_ready/fill_ready combinational, 1 in IDLE absent competing inputs.
- Lookup latency: accepted in cycle N → resp_valid=1 in cycle N+1 only. Back-to-back lookups: one per cycle.
- Fill accepted in cycle N is visible to a lookup accepted in N+1.
- Flush: accepted in N, sets cleared in N+1..N+SETS, flush_done in N+SETS; req_ready=fill_ready=0 from N through N+SETS.
- Reset mid-flush: FSM to IDLE, all entries invalid, no flush_done.

## Configuration
- TLB_PERF_CNT_EN defined: perf_hits/perf_misses increment on each resp_valid with resp_hit=1/0; saturate at 32'hFFFF_FFFF; reset to 0.
- Undefined: counter logic absent, both ports tied to 0.

## Test plan
- Empty TLB: lookup vaddr=0x0000_0000_0000_5123, pcid=3 → N+1: resp_hit=0, resp_paddr=0.
- Fill vaddr 0x5000, pcid 3, ppn 0xABCDE; lookup 0x5123 pcid 3 → hit, paddr 0xABCDE123; same vaddr with pcid 4 → miss.
- Fill 9 distinct tags into set 5 (vaddr = (t<<15)|0x5000, t=1..9), no intervening lookups → tag 1 evicted (WAYS=8), tags 2..9 hit.
- Fill tags 1..8 into set 2, lookup tag 1, fill tag 9 → tag 1 still hits; tag 5 (PLRU victim) misses.
- Fill pcid 1 and pcid 2 entries; flush_all=0, flush_pcid=1 → flush_done exactly 8 cycles after accept, req_ready low throughout; pcid 1 misses, pcid 2 hits.
- Assert rst_n low mid-flush and during back-to-back hits → all outputs at reset values, subsequent lookups miss; with TLB_PERF_CNT_EN, 3 hits + 2 misses → perf_hits=3, perf_misses=2.
